sc_stream_counter: RTL and testbench

- Downstream stochastic-to-binary stage for the SNG/LFSR circuit block.
- Counts the 1s in a stochastic bitstream (`output_circuit`) over a fixed window of `LEN` valid samples and returns the binary count through a valid/ready handshake.
- Drives the run enable of the upstream stage, so the LFSR advances only while a window is being counted.

---
 rtl/sc_stream_counter.sv | 96 +++++++++
 tb/tb_sc_stream_counter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_counter.sv
// sc_stream_counter: counts the 1s in a stochastic bitstream over a window of 2^LEN_LOG2 valid samples.
// Latency: result_valid rises on the edge that samples the last valid bit (LEN+1 edges after start with bit_valid held high).
// Backpressure: result is held in HOLD until result_ready; sng_en stalls the upstream source outside RUN.
module sc_stream_counter #(
    parameter int LEN_LOG2 = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                sng_en,
    output logic                busy,
    output logic [LEN_LOG2:0]   result,
    output logic                result_valid,
    input  logic                result_ready
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [LEN_LOG2-1:0] LAST_SAMPLE = '1;

    state_t              state, state_nxt;
    logic [LEN_LOG2:0]   ones, ones_nxt;
    logic [LEN_LOG2-1:0] samples, samples_nxt;
    logic [LEN_LOG2:0]   result_nxt;
    logic                result_valid_nxt;
    logic [LEN_LOG2:0]   ones_inc;

    assign ones_inc = ones + {{LEN_LOG2{1'b0}}, bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ones         <= '0;
            samples      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            ones         <= ones_nxt;
            samples      <= samples_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        ones_nxt         = ones;
        samples_nxt      = samples;
        result_nxt       = result;
        result_valid_nxt = result_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    ones_nxt    = '0;
                    samples_nxt = '0;
                end
            end
            RUN: begin
                // abort outranks a final sample arriving in the same cycle
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bit_valid) begin
                    ones_nxt    = ones_inc;
                    samples_nxt = samples + LEN_LOG2'(1);
                    if (samples == LAST_SAMPLE) begin
                        state_nxt        = HOLD;
                        result_nxt       = ones_inc;
                        result_valid_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (result_ready) begin
                    result_valid_nxt = 1'b0;
                    if (start) begin
                        state_nxt   = RUN;
                        ones_nxt    = '0;
                        samples_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sng_en = (state == RUN);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_sc_stream_counter.sv
// Directed bench for sc_stream_counter with LEN = 256; inputs driven and outputs sampled on the falling edge.
module tb_sc_stream_counter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       bit_in;
    logic       bit_valid;
    logic       sng_en;
    logic       busy;
    logic [8:0] result;
    logic       result_valid;
    logic       result_ready;

    int checks   = 0;
    int failures = 0;

    sc_stream_counter #(.LEN_LOG2(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .sng_en       (sng_en),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // mode 0: all ones, 1: alternating 1/0, 2: all zeros, 3: valid every other cycle with bit_in=1
    task automatic run_stream(input bit do_start, input int mode, output int cycles, output int en_cnt);
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cycles = 0;
        en_cnt = 0;
        while (!result_valid && cycles < 1200) begin
            if (sng_en) en_cnt++;
            case (mode)
                0: begin bit_valid = 1'b1; bit_in = 1'b1; end
                1: begin bit_valid = 1'b1; bit_in = (cycles % 2 == 0); end
                2: begin bit_valid = 1'b1; bit_in = 1'b0; end
                default: begin bit_valid = (cycles % 2 == 1); bit_in = 1'b1; end
            endcase
            cycles++;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, sng_en, result_valid, result} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%0b sng_en=%0b rv=%0b result=%0d expected all 0",
                     busy, sng_en, result_valid, result);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy got %0b expected 0", busy);
        end
    endtask

    task automatic test_all_ones;
        int cyc, en;
        run_stream(1'b1, 0, cyc, en);
        checks++;
        if (cyc !== 256) begin failures++; $display("FAIL ones_latency: got %0d cycles expected 256", cyc); end
        checks++;
        if (en !== 256) begin failures++; $display("FAIL ones_sng_en_len: got %0d expected 256", en); end
        checks++;
        if (result !== 9'd256) begin failures++; $display("FAIL ones_result: got %0d expected 256", result); end
        checks++;
        if (sng_en !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ones_hold_state: got sng_en=%0b busy=%0b expected 0 1", sng_en, busy);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ones_handshake: got rv=%0b busy=%0b expected 0 0", result_valid, busy);
        end
        checks++;
        if (result !== 9'd256) begin failures++; $display("FAIL ones_result_kept: got %0d expected 256", result); end
    endtask

    task automatic test_alternating;
        int cyc, en;
        run_stream(1'b1, 1, cyc, en);
        checks++;
        if (cyc !== 256 || result !== 9'd128) begin
            failures++;
            $display("FAIL alt_result: got cycles=%0d result=%0d expected 256 128", cyc, result);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_abort_mid;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        bit_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || sng_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_mid_idle: got busy=%0b sng_en=%0b expected 0 0", busy, sng_en);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result_valid !== 1'b0) begin failures++; $display("FAIL abort_mid_rv: got %0b expected 0", result_valid); end
        checks++;
        if (result !== 9'd128) begin failures++; $display("FAIL abort_mid_result: got %0d expected 128", result); end
    endtask

    task automatic test_zeros;
        int cyc, en;
        run_stream(1'b1, 2, cyc, en);
        checks++;
        if (cyc !== 256 || result !== 9'd0) begin
            failures++;
            $display("FAIL zeros_result: got cycles=%0d result=%0d expected 256 0", cyc, result);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_half_rate;
        int cyc, en;
        run_stream(1'b1, 3, cyc, en);
        checks++;
        if (cyc !== 512) begin failures++; $display("FAIL half_rate_cycles: got %0d expected 512", cyc); end
        checks++;
        if (result !== 9'd256) begin failures++; $display("FAIL half_rate_result: got %0d expected 256", result); end
        checks++;
        if (en !== 512) begin failures++; $display("FAIL half_rate_sng_en: got %0d expected 512", en); end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc, en;
        int bad;
        run_stream(1'b1, 1, cyc, en);
        checks++;
        if (result !== 9'd128 || result_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: got result=%0d rv=%0b expected 128 1", result, result_valid);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start     = (i == 3);
            abort     = (i == 6);
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(negedge clk);
            if (result !== 9'd128 || result_valid !== 1'b1 || busy !== 1'b1 || sng_en !== 1'b0) bad++;
        end
        start     = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        result_ready = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        start        = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || sng_en !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: got rv=%0b sng_en=%0b expected 0 1", result_valid, sng_en);
        end
        run_stream(1'b0, 1, cyc, en);
        checks++;
        if (cyc !== 256 || result !== 9'd128) begin
            failures++;
            $display("FAIL b2b_second: got cycles=%0d result=%0d expected 256 128", cyc, result);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_abort_last;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 255; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        bit_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_last: got rv=%0b busy=%0b expected 0 0", result_valid, busy);
        end
        checks++;
        if (result !== 9'd128) begin failures++; $display("FAIL abort_last_result: got %0d expected 128", result); end
    endtask

    task automatic test_async_reset;
        int cyc, en;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, sng_en, result_valid, result} !== 12'd0) begin
            failures++;
            $display("FAIL async_reset: got busy=%0b sng_en=%0b rv=%0b result=%0d expected all 0",
                     busy, sng_en, result_valid, result);
        end
        bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_stream(1'b1, 0, cyc, en);
        checks++;
        if (cyc !== 256 || result !== 9'd256) begin
            failures++;
            $display("FAIL after_reset_window: got cycles=%0d result=%0d expected 256 256", cyc, result);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL after_reset_idle: busy got %0b expected 0", busy); end
    endtask

    initial begin
        start        = 1'b0;
        abort        = 1'b0;
        bit_in       = 1'b0;
        bit_valid    = 1'b0;
        result_ready = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        test_reset;
        test_all_ones;
        test_alternating;
        test_abort_mid;
        test_zeros;
        test_half_rate;
        test_back_to_back;
        test_abort_last;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
